// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI write controller.
package spi_pkg;

    localparam int SPI_BYTE_W        = 8;
    localparam int SPI_BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRIME_HI,
        PRIME_LO,
        SHIFT,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_o pulses on the last cycle of every CLK_DIV-cycle window.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Held at zero while disabled so each phase starts a full window on entry.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_write_ctrl.sv
// Byte-level SPI master controller feeding a falling-edge-loaded, MSB-first write shift register.
module spi_write_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SPI_BYTE_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    input  logic                  tx_last_i,
    output logic                  tx_ready_o,
    output logic                  spi_clk_o,
    output logic                  cs_n_o,
    output logic                  load_data_en_o,
    output logic [SPI_BYTE_W-1:0] data_o,
    output logic                  done_o,
    output logic                  underrun_o,
    output logic [7:0]            frame_bytes_o
);

    localparam logic [2:0] LAST_BIT     = 3'(SPI_BITS_PER_BYTE - 1);
    localparam logic [2:0] PRE_LAST_BIT = 3'(SPI_BITS_PER_BYTE - 2);

    spi_state_e            state_q, state_d;
    logic [2:0]            bit_q, bit_d;
    logic                  phase_hi_q, phase_hi_d;
    logic [SPI_BYTE_W-1:0] hold_data_q, hold_data_d;
    logic                  hold_last_q, hold_last_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  last_acc_q, last_acc_d;
    logic                  loaded_q, loaded_d;
    logic                  cur_last_q, cur_last_d;
    logic [7:0]            byte_cnt_q, byte_cnt_d;
    logic                  spi_clk_q, spi_clk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  load_en_q, load_en_d;
    logic [SPI_BYTE_W-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic [7:0]            frame_bytes_q, frame_bytes_d;

    logic tick;
    logic accept;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q != IDLE),
        .tick_o(tick)
    );

    // tx valid/ready: a byte transfers on any clock edge where both are high;
    // ready never depends on tx_valid_i, and data/last are sampled only then.
    assign tx_ready_o = !rst_i && !hold_valid_q && !last_acc_q && (state_q != HOLD);
    assign accept     = tx_valid_i && tx_ready_o;

    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        phase_hi_d    = phase_hi_q;
        hold_data_d   = hold_data_q;
        hold_last_d   = hold_last_q;
        hold_valid_d  = hold_valid_q;
        last_acc_d    = last_acc_q;
        loaded_d      = loaded_q;
        cur_last_d    = cur_last_q;
        byte_cnt_d    = byte_cnt_q;
        spi_clk_d     = spi_clk_q;
        cs_n_d        = cs_n_q;
        load_en_d     = load_en_q;
        data_d        = data_q;
        done_d        = 1'b0;
        underrun_d    = 1'b0;
        frame_bytes_d = frame_bytes_q;

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = tx_data_i;
            hold_last_d  = tx_last_i;
            if (tx_last_i) begin
                last_acc_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                // A byte accepted while idle is forwarded straight to the load
                // path so PRIME_HI starts on the very next cycle.
                if (hold_valid_q || accept) begin
                    state_d      = PRIME_HI;
                    spi_clk_d    = 1'b1;
                    load_en_d    = 1'b1;
                    byte_cnt_d   = '0;
                    hold_valid_d = 1'b0;
                    if (hold_valid_q) begin
                        data_d     = hold_data_q;
                        cur_last_d = hold_last_q;
                    end else begin
                        data_d     = tx_data_i;
                        cur_last_d = tx_last_i;
                    end
                end
            end
            PRIME_HI: begin
                if (tick) begin
                    state_d   = PRIME_LO;
                    spi_clk_d = 1'b0;
                    cs_n_d    = 1'b0;
                    load_en_d = 1'b0;
                end
            end
            PRIME_LO: begin
                if (tick) begin
                    state_d    = SHIFT;
                    bit_d      = '0;
                    phase_hi_d = 1'b1;
                    spi_clk_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (phase_hi_q) begin
                        phase_hi_d = 1'b0;
                        spi_clk_d  = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            load_en_d = 1'b0;
                        end
                    end else if (bit_q == LAST_BIT) begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (loaded_q) begin
                            bit_d      = '0;
                            phase_hi_d = 1'b1;
                            spi_clk_d  = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        bit_d      = bit_q + 3'd1;
                        phase_hi_d = 1'b1;
                        spi_clk_d  = 1'b1;
                        // Entering the bit-7 high half: only a byte already held counts.
                        if (bit_q == PRE_LAST_BIT) begin
                            if (hold_valid_q) begin
                                load_en_d    = 1'b1;
                                data_d       = hold_data_q;
                                cur_last_d   = hold_last_q;
                                hold_valid_d = 1'b0;
                                loaded_d     = 1'b1;
                            end else begin
                                load_en_d = 1'b0;
                                loaded_d  = 1'b0;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d       = IDLE;
                    cs_n_d        = 1'b1;
                    done_d        = 1'b1;
                    frame_bytes_d = byte_cnt_q;
                    underrun_d    = !cur_last_q;
                    last_acc_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            bit_q         <= '0;
            phase_hi_q    <= 1'b0;
            hold_data_q   <= '0;
            hold_last_q   <= 1'b0;
            hold_valid_q  <= 1'b0;
            last_acc_q    <= 1'b0;
            loaded_q      <= 1'b0;
            cur_last_q    <= 1'b0;
            byte_cnt_q    <= '0;
            spi_clk_q     <= 1'b0;
            cs_n_q        <= 1'b1;
            load_en_q     <= 1'b0;
            data_q        <= '0;
            done_q        <= 1'b0;
            underrun_q    <= 1'b0;
            frame_bytes_q <= '0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            phase_hi_q    <= phase_hi_d;
            hold_data_q   <= hold_data_d;
            hold_last_q   <= hold_last_d;
            hold_valid_q  <= hold_valid_d;
            last_acc_q    <= last_acc_d;
            loaded_q      <= loaded_d;
            cur_last_q    <= cur_last_d;
            byte_cnt_q    <= byte_cnt_d;
            spi_clk_q     <= spi_clk_d;
            cs_n_q        <= cs_n_d;
            load_en_q     <= load_en_d;
            data_q        <= data_d;
            done_q        <= done_d;
            underrun_q    <= underrun_d;
            frame_bytes_q <= frame_bytes_d;
        end
    end

    assign spi_clk_o      = spi_clk_q;
    assign cs_n_o         = cs_n_q;
    assign load_data_en_o = load_en_q;
    assign data_o         = data_q;
    assign done_o         = done_q;
    assign underrun_o     = underrun_q;
    assign frame_bytes_o  = frame_bytes_q;

endmodule
